// File: rtl/clock_ctrl_panel.sv
// clock_ctrl_panel: debounced run/halt, single-step and stretched reset front end for the clock divider
module clock_ctrl_panel #(
  parameter int DEB_CYCLES  = 250000,
  parameter int RST_STRETCH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_rst,
  input  logic        btn_step,
  input  logic        sw_run,
  input  logic [1:0]  sw_speed,
  input  logic        halt_req,
  input  logic        clk_out,
  output logic        cpu_reset,
  output logic        Halt,
  output logic        freq10,
  output logic        freq100,
  output logic [15:0] step_count
);
  localparam int CW = $clog2(DEB_CYCLES);
  localparam int SW = $clog2(RST_STRETCH + 1);
  typedef enum logic [1:0] {HALTED, RUN, STEP_LOW, STEP_HIGH} state_t;
  state_t state;
  logic [4:0] raw, s1, s2, db;
  logic [SW-1:0] stretch;
  logic step_q, step_edge, halt_latched;
  assign raw = {btn_rst, btn_step, sw_run, sw_speed};
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end
  for (genvar i = 0; i < 5; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic d;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
        d <= 1'b0;
      end else if (s2[i] == d) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt <= '0;
        d <= s2[i];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
    assign db[i] = d;
  end
  assign step_edge = db[3] && !step_q;
  assign Halt = (state == HALTED) || (state == STEP_HIGH && clk_out);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HALTED;
      halt_latched <= 1'b0;
      step_count <= '0;
      freq10 <= 1'b0;
      freq100 <= 1'b0;
      cpu_reset <= 1'b1;
      stretch <= SW'(RST_STRETCH);
      step_q <= 1'b0;
    end else begin
      freq10 <= db[1];
      freq100 <= db[0];
      step_q <= db[3];
      cpu_reset <= db[4] || (stretch != '0);
      stretch <= db[4] ? SW'(RST_STRETCH) : (stretch != '0) ? stretch - SW'(1) : stretch;
      halt_latched <= !cpu_reset && (halt_latched || halt_req);
      step_count <= cpu_reset ? '0 : step_count + 16'(state == STEP_HIGH && clk_out);
      if (cpu_reset) state <= HALTED;
      else case (state)
        RUN:       if (!db[2] || halt_latched) state <= HALTED;
        HALTED:    if (step_edge) state <= STEP_LOW;
                   else if (db[2] && !halt_latched) state <= RUN;
        STEP_LOW:  if (!clk_out) state <= STEP_HIGH;
        STEP_HIGH: if (clk_out) state <= HALTED;
        default:   state <= HALTED;
      endcase
    end
  end
endmodule

// File: tb/tb_clock_ctrl_panel.sv
// tb_clock_ctrl_panel: directed plus randomized checks of clock_ctrl_panel against a behavioural model
module tb_clock_ctrl_panel;
  localparam int DEB = 4;
  localparam int RS = 3;
  logic clk = 0, reset = 1, btn_rst = 0, btn_step = 0, sw_run = 0, halt_req = 0, clk_out = 0;
  logic [1:0] sw_speed = 0;
  logic cpu_reset, Halt, freq10, freq100;
  logic [15:0] step_count;
  int checks = 0, errors = 0;
  logic [4:0] hist [DEB+2];
  logic [4:0] m_db;
  logic [1:0] m_freq;
  logic m_step_prev, m_hl, m_cr;
  int m_since, m_mode, m_cnt;
  int div_cnt = 0, div_half = 3, rises = 0;
  always #5 clk = ~clk;
  clock_ctrl_panel #(.DEB_CYCLES(DEB), .RST_STRETCH(RS)) dut (
    .clk(clk), .reset(reset), .btn_rst(btn_rst), .btn_step(btn_step), .sw_run(sw_run),
    .sw_speed(sw_speed), .halt_req(halt_req), .clk_out(clk_out), .cpu_reset(cpu_reset),
    .Halt(Halt), .freq10(freq10), .freq100(freq100), .step_count(step_count)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic m_halt();
    return m_mode == 0 || (m_mode == 3 && clk_out);
  endfunction
  // Model state: mode 0 halted, 1 running, 2 waiting for clk_out low, 3 waiting for clk_out high.
  task automatic model_edge();
    logic [4:0] raw;
    logic step_edge, flip;
    int nmode;
    raw = {btn_rst, btn_step, sw_run, sw_speed};
    if (reset) begin
      for (int j = 0; j < DEB + 2; j++) hist[j] = '0;
      m_db = '0; m_freq = '0; m_step_prev = 0; m_hl = 0; m_cr = 1;
      m_since = 0; m_mode = 0; m_cnt = 0;
      return;
    end
    step_edge = m_db[3] && !m_step_prev;
    nmode = m_mode;
    if (m_cr) nmode = 0;
    else if (m_mode == 1 && (!m_db[2] || m_hl)) nmode = 0;
    else if (m_mode == 0 && step_edge) nmode = 2;
    else if (m_mode == 0 && m_db[2] && !m_hl) nmode = 1;
    else if (m_mode == 2 && !clk_out) nmode = 3;
    else if (m_mode == 3 && clk_out) nmode = 0;
    m_cnt = m_cr ? 0 : (m_mode == 3 && clk_out) ? (m_cnt + 1) % 65536 : m_cnt;
    m_hl = !m_cr && (m_hl || halt_req);
    m_since = m_db[4] ? 0 : (m_since < 1000 ? m_since + 1 : m_since);
    m_freq = m_db[1:0];
    m_step_prev = m_db[3];
    m_mode = nmode;
    for (int j = DEB + 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = raw;
    // A debounced bit follows the raw input once DEB consecutive samples, two edges old, all disagree with it.
    for (int b = 0; b < 5; b++) begin
      flip = 1;
      for (int j = 2; j < DEB + 2; j++) if (hist[j][b] == m_db[b]) flip = 0;
      if (flip) m_db[b] = !m_db[b];
    end
    m_cr = m_since <= RS;
  endtask
  task automatic cycle();
    logic nxt;
    @(negedge clk);
    nxt = clk_out;
    if (!(Halt && clk_out)) begin
      if (div_cnt >= div_half - 1) begin
        nxt = !clk_out;
        div_cnt = 0;
      end else div_cnt++;
    end
    @(posedge clk);
    model_edge();
    #1;
    if (nxt && !clk_out) rises++;
    clk_out = nxt;
    #1;
    check("cpu_reset", cpu_reset, m_cr);
    check("Halt", Halt, m_halt());
    check("freq10", freq10, m_freq[1]);
    check("freq100", freq100, m_freq[0]);
    check("step_count", step_count, m_cnt);
  endtask
  initial begin
    int n;
    reset = 1;
    repeat (2) cycle();
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_halt", Halt, 1);
    check("rst_count", step_count, 0);
    check("rst_freq", {freq10, freq100}, 0);
    reset = 0;
    for (int i = 0; i < RS; i++) begin
      cycle();
      check("stretch_high", cpu_reset, 1);
    end
    cycle();
    check("stretch_low", cpu_reset, 0);
    sw_run = 1; cycle();
    sw_run = 0; cycle();
    sw_run = 1;
    for (int i = 0; i < DEB + 2; i++) begin
      cycle();
      check("run_wait", Halt, 1);
    end
    cycle();
    check("run_enter", Halt, 0);
    repeat (3) cycle();
    halt_req = 1; cycle();
    check("halt_req_edge", Halt, 0);
    halt_req = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("halt_held", Halt, 1);
    end
    btn_rst = 1; repeat (8) cycle();
    btn_rst = 0;
    n = 0;
    while (Halt !== 1'b0 && n < 40) begin
      cycle();
      n++;
    end
    check("rst_resume_run", Halt, 0);
    check("rst_resume_cr", cpu_reset, 0);
    sw_run = 0; repeat (15) cycle();
    check("halted", Halt, 1);
    check("stalled_high", clk_out, 1);
    div_half = 8;
    rises = 0;
    btn_step = 1; repeat (5) cycle();
    btn_step = 0; repeat (5) cycle();
    btn_step = 1; repeat (6) cycle();
    btn_step = 0; repeat (30) cycle();
    check("step1_rises", rises, 1);
    check("step1_count", step_count, 1);
    check("step1_halt", Halt, 1);
    div_half = 3;
    sw_speed = 2'b11;
    repeat (DEB + 2) cycle();
    check("speed_wait", {freq10, freq100}, 2'b00);
    cycle();
    check("speed_set", {freq10, freq100}, 2'b11);
    rises = 0;
    btn_step = 1; repeat (6) cycle();
    btn_step = 0; repeat (20) cycle();
    check("step2_rises", rises, 1);
    check("step2_count", step_count, 2);
    force dut.step_count = 16'hFFFF;
    m_cnt = 65535;
    cycle();
    release dut.step_count;
    cycle();
    rises = 0;
    btn_step = 1; repeat (6) cycle();
    btn_step = 0; repeat (20) cycle();
    check("wrap_rises", rises, 1);
    check("wrap_count", step_count, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29) == 0) sw_run = !sw_run;
      if ($urandom_range(9) == 0) btn_step = !btn_step;
      btn_rst = btn_rst ? ($urandom_range(5) != 0) : ($urandom_range(199) == 0);
      if ($urandom_range(39) == 0) sw_speed = sw_speed ^ 2'($urandom_range(1, 2));
      halt_req = ($urandom_range(59) == 0);
      reset = ($urandom_range(999) == 0);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
